// File: rtl/bank_biu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bank_biu_ctrl
// Purpose  : Cache-bank bus interface unit. Turns HTU refill / writeback
//            requests into AXI3 bursts; reassembles refill beats into a
//            256-bit line for the ISU and streams buffered writeback lines
//            out on AW/W, closing on B.
// Options  : BIU_ERR_CHECK_EN - enables sticky read/write error reporting
//            on biu_err_o (tied to zero when undefined).
// Revision : 1.0 - initial release
// ============================================================================
module bank_biu_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int BUS_WIDTH  = 256,
  parameter int ID_WIDTH   = 6,
  parameter int RD_OTS     = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  // HTU request
  input  logic                     htu_biu_valid_i,
  output logic                     htu_biu_ready_o,
  input  logic [1:0]               htu_biu_opcode_i,
  input  logic [ID_WIDTH-1:0]      htu_biu_set_way_i,
  input  logic [ADDR_WIDTH-6:0]    htu_biu_addr_i,
  // SRAM controller writeback data
  input  logic                     sc_biu_valid_i,
  output logic                     sc_biu_ready_o,
  input  logic [127:0]             sc_biu_data_i,
  input  logic                     sc_biu_offset_i,
  // ISU refill return
  output logic                     biu_isu_rvalid_o,
  input  logic                     biu_isu_rready_i,
  output logic [255:0]             biu_isu_rdata_o,
  output logic [ID_WIDTH-1:0]      biu_isu_rid_o,
  // AXI3 AR
  output logic                     biu_axi3_arvalid_o,
  input  logic                     biu_axi3_arready_i,
  output logic [ADDR_WIDTH-1:0]    biu_axi3_araddr_o,
  output logic [ID_WIDTH-1:0]      biu_axi3_arid_o,
  output logic [3:0]               biu_axi3_arlen_o,
  output logic [2:0]               biu_axi3_arsize_o,
  output logic [1:0]               biu_axi3_arburst_o,
  // AXI3 R
  input  logic                     biu_axi3_rvalid_i,
  output logic                     biu_axi3_rready_o,
  input  logic [BUS_WIDTH-1:0]     biu_axi3_rdata_i,
  input  logic [ID_WIDTH-1:0]      biu_axi3_rid_i,
  input  logic [1:0]               biu_axi3_rresp_i,
  input  logic                     biu_axi3_rlast_i,
  // AXI3 AW
  output logic                     biu_axi3_awvalid_o,
  input  logic                     biu_axi3_awready_i,
  output logic [ADDR_WIDTH-1:0]    biu_axi3_awaddr_o,
  output logic [ID_WIDTH-1:0]      biu_axi3_awid_o,
  output logic [3:0]               biu_axi3_awlen_o,
  output logic [2:0]               biu_axi3_awsize_o,
  output logic [1:0]               biu_axi3_awburst_o,
  // AXI3 W
  output logic                     biu_axi3_wvalid_o,
  input  logic                     biu_axi3_wready_i,
  output logic [BUS_WIDTH-1:0]     biu_axi3_wdata_o,
  output logic [BUS_WIDTH/8-1:0]   biu_axi3_wstrb_o,
  output logic                     biu_axi3_wlast_o,
  output logic [ID_WIDTH-1:0]      biu_axi3_wid_o,
  // AXI3 B
  input  logic                     biu_axi3_bvalid_i,
  output logic                     biu_axi3_bready_o,
  input  logic [ID_WIDTH-1:0]      biu_axi3_bid_i,
  input  logic [1:0]               biu_axi3_bresp_i,
  // Error reporting
  output logic [1:0]               biu_err_o,
  input  logic                     biu_err_clr_i
);

  localparam int BEATS  = 256 / BUS_WIDTH;
  localparam int SIZE   = $clog2(BUS_WIDTH / 8);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W  = $clog2(RD_OTS + 1);

  localparam logic [3:0]        C_LEN       = 4'(BEATS - 1);
  localparam logic [2:0]        C_SIZE      = 3'(SIZE);
  localparam logic [1:0]        C_INCR      = 2'b01;
  localparam logic [BEAT_W-1:0] C_LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0]  C_RD_OTS    = CNT_W'(RD_OTS);

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_ADDR = 2'd1,
    WB_DATA = 2'd2,
    WB_RESP = 2'd3
  } wb_state_t;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  logic                  arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [ID_WIDTH-1:0]   arid_q, arid_d;
  logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
  wb_state_t             wb_state_q;
  logic                  rd_accept, wb_accept;

  // Per-opcode acceptance; reserved opcodes are always taken and dropped
  always_comb begin
    htu_biu_ready_o = 1'b1;
    case (htu_biu_opcode_i)
      2'b00:   htu_biu_ready_o = ~arvalid_q & (rd_cnt_q < C_RD_OTS);
      2'b01:   htu_biu_ready_o = (wb_state_q == WB_IDLE);
      default: htu_biu_ready_o = 1'b1;
    endcase
  end

  assign rd_accept = htu_biu_valid_i & htu_biu_ready_o & (htu_biu_opcode_i == 2'b00);
  assign wb_accept = htu_biu_valid_i & htu_biu_ready_o & (htu_biu_opcode_i == 2'b01);

  // --------------------------------------------------------------------------
  // Refill: AR register and outstanding counter
  // --------------------------------------------------------------------------
  logic isu_hs;
  logic isu_rvalid_q, isu_rvalid_d;

  assign isu_hs = isu_rvalid_q & biu_isu_rready_i;

  // AR holding register loaded on accept and released on arready
  always_comb begin
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arid_d    = arid_q;
    if (rd_accept) begin
      arvalid_d = 1'b1;
      araddr_d  = {htu_biu_addr_i, 5'b0};
      arid_d    = htu_biu_set_way_i;
    end else if (arvalid_q && biu_axi3_arready_i) begin
      arvalid_d = 1'b0;
    end
  end

  // Lines in flight: counted from accept until the ISU takes the line
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    case ({rd_accept, isu_hs})
      2'b10:   rd_cnt_d = rd_cnt_q + CNT_W'(1);
      2'b01:   rd_cnt_d = rd_cnt_q - CNT_W'(1);
      default: rd_cnt_d = rd_cnt_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Refill: R beat assembly into the single line buffer
  // --------------------------------------------------------------------------
  logic                r_hs, rlast_mis;
  logic [BEAT_W-1:0]   rbeat_q, rbeat_d;
  logic [8:0]          rbeat_base;
  logic [255:0]        line_q, line_d;
  logic [ID_WIDTH-1:0] rid_q, rid_d;

  // The buffer doubles as the ISU output; new beats land only once it drains
  assign biu_axi3_rready_o = ~isu_rvalid_q | biu_isu_rready_i;
  assign r_hs              = biu_axi3_rvalid_i & biu_axi3_rready_o;
  assign rbeat_base        = 9'(rbeat_q) * 9'(BUS_WIDTH);
  assign rlast_mis         = biu_axi3_rlast_i & (rbeat_q != C_LAST_BEAT);

  // Beat placement, line completion and ISU valid tracking
  always_comb begin
    rbeat_d      = rbeat_q;
    line_d       = line_q;
    rid_d        = rid_q;
    isu_rvalid_d = isu_rvalid_q & ~biu_isu_rready_i;
    if (r_hs) begin
      line_d[rbeat_base +: BUS_WIDTH] = biu_axi3_rdata_i;
      if (biu_axi3_rlast_i) begin
        rbeat_d      = '0;
        rid_d        = biu_axi3_rid_i;
        isu_rvalid_d = 1'b1;
      end else if (rbeat_q == C_LAST_BEAT) begin
        rbeat_d = '0;
      end else begin
        rbeat_d = rbeat_q + BEAT_W'(1);
      end
    end
  end

  // Refill-side state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      arid_q       <= '0;
      rd_cnt_q     <= '0;
      rbeat_q      <= '0;
      line_q       <= '0;
      rid_q        <= '0;
      isu_rvalid_q <= 1'b0;
    end else begin
      arvalid_q    <= arvalid_d;
      araddr_q     <= araddr_d;
      arid_q       <= arid_d;
      rd_cnt_q     <= rd_cnt_d;
      rbeat_q      <= rbeat_d;
      line_q       <= line_d;
      rid_q        <= rid_d;
      isu_rvalid_q <= isu_rvalid_d;
    end
  end

  assign biu_axi3_arvalid_o = arvalid_q;
  assign biu_axi3_araddr_o  = araddr_q;
  assign biu_axi3_arid_o    = arid_q;
  assign biu_axi3_arlen_o   = C_LEN;
  assign biu_axi3_arsize_o  = C_SIZE;
  assign biu_axi3_arburst_o = C_INCR;
  assign biu_isu_rvalid_o   = isu_rvalid_q;
  assign biu_isu_rdata_o    = line_q;
  assign biu_isu_rid_o      = rid_q;

  // --------------------------------------------------------------------------
  // Writeback: half-line capture buffer
  // --------------------------------------------------------------------------
  logic         sc_hs;
  logic [1:0]   wb_fill_q, wb_fill_d;
  logic [255:0] wb_buf_q, wb_buf_d;

  assign sc_biu_ready_o = ((wb_state_q == WB_ADDR) || (wb_state_q == WB_DATA)) &
                          ~wb_fill_q[sc_biu_offset_i];
  assign sc_hs          = sc_biu_valid_i & sc_biu_ready_o;

  // Each half is taken once per transaction; fill flags reset on a new accept
  always_comb begin
    wb_fill_d = wb_fill_q;
    wb_buf_d  = wb_buf_q;
    if (wb_accept) begin
      wb_fill_d = 2'b00;
    end else if (sc_hs) begin
      wb_fill_d[sc_biu_offset_i] = 1'b1;
      if (sc_biu_offset_i) wb_buf_d[255:128] = sc_biu_data_i;
      else                 wb_buf_d[127:0]   = sc_biu_data_i;
    end
  end

  // Writeback buffer registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_fill_q <= 2'b00;
      wb_buf_q  <= '0;
    end else begin
      wb_fill_q <= wb_fill_d;
      wb_buf_q  <= wb_buf_d;
    end
  end

  // --------------------------------------------------------------------------
  // Writeback FSM: IDLE -> ADDR -> DATA -> RESP -> IDLE
  // --------------------------------------------------------------------------
  logic                  awvalid_q, aw_done_q, wvalid_q, bready_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [ID_WIDTH-1:0]   awid_q;
  logic [BEAT_W-1:0]     wbeat_q;
  logic [8:0]            wbeat_base;
  logic                  aw_hs;

  assign aw_hs = awvalid_q & biu_axi3_awready_i;

  // Sequencer with registered channel valids; DATA entered only once the
  // address is out and both halves (including one arriving now) are held
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_state_q <= WB_IDLE;
      awvalid_q  <= 1'b0;
      aw_done_q  <= 1'b0;
      awaddr_q   <= '0;
      awid_q     <= '0;
      wvalid_q   <= 1'b0;
      wbeat_q    <= '0;
      bready_q   <= 1'b0;
    end else begin
      case (wb_state_q)
        WB_IDLE: begin
          if (wb_accept) begin
            wb_state_q <= WB_ADDR;
            awvalid_q  <= 1'b1;
            aw_done_q  <= 1'b0;
            awaddr_q   <= {htu_biu_addr_i, 5'b0};
            awid_q     <= htu_biu_set_way_i;
          end
        end
        WB_ADDR: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if ((aw_done_q || aw_hs) && (wb_fill_d == 2'b11)) begin
            wb_state_q <= WB_DATA;
            wvalid_q   <= 1'b1;
            wbeat_q    <= '0;
          end
        end
        WB_DATA: begin
          if (biu_axi3_wready_i) begin
            if (wbeat_q == C_LAST_BEAT) begin
              wvalid_q   <= 1'b0;
              bready_q   <= 1'b1;
              wb_state_q <= WB_RESP;
            end else begin
              wbeat_q <= wbeat_q + BEAT_W'(1);
            end
          end
        end
        WB_RESP: begin
          if (biu_axi3_bvalid_i) begin
            bready_q   <= 1'b0;
            wb_state_q <= WB_IDLE;
          end
        end
        default: wb_state_q <= WB_IDLE;
      endcase
    end
  end

  assign wbeat_base         = 9'(wbeat_q) * 9'(BUS_WIDTH);
  assign biu_axi3_awvalid_o = awvalid_q;
  assign biu_axi3_awaddr_o  = awaddr_q;
  assign biu_axi3_awid_o    = awid_q;
  assign biu_axi3_awlen_o   = C_LEN;
  assign biu_axi3_awsize_o  = C_SIZE;
  assign biu_axi3_awburst_o = C_INCR;
  assign biu_axi3_wvalid_o  = wvalid_q;
  assign biu_axi3_wdata_o   = wb_buf_q[wbeat_base +: BUS_WIDTH];
  assign biu_axi3_wstrb_o   = '1;
  assign biu_axi3_wlast_o   = wvalid_q & (wbeat_q == C_LAST_BEAT);
  assign biu_axi3_wid_o     = awid_q;
  assign biu_axi3_bready_o  = bready_q;

  // B carries no information beyond completion; its id is not compared
  logic unused_bid;
  assign unused_bid = ^biu_axi3_bid_i;

  // --------------------------------------------------------------------------
  // Sticky error flags
  // --------------------------------------------------------------------------
`ifdef BIU_ERR_CHECK_EN
  logic [1:0] err_q, err_d;

  // Clear first so a same-cycle error still lands
  always_comb begin
    err_d = err_q;
    if (biu_err_clr_i) err_d = 2'b00;
    if (r_hs && ((biu_axi3_rresp_i != 2'b00) || rlast_mis)) err_d[0] = 1'b1;
    if (bready_q && biu_axi3_bvalid_i && (biu_axi3_bresp_i != 2'b00)) err_d[1] = 1'b1;
  end

  // Error flag register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 2'b00;
    else       err_q <= err_d;
  end

  assign biu_err_o = err_q;
`else
  logic unused_err;
  assign unused_err = ^{biu_axi3_rresp_i, biu_axi3_bresp_i, biu_err_clr_i, rlast_mis};
  assign biu_err_o  = 2'b00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bank_biu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bank_biu_ctrl
// Purpose  : Self-checking bench for bank_biu_ctrl at BUS_WIDTH=128
//            (two beats per line). Refill vectors come from a table, ISU
//            lines and W beats are checked against scoreboard queues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bank_biu_ctrl;

  localparam int BW = 128;
`ifdef BIU_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_i;
  logic htu_valid, htu_ready, sc_valid, sc_ready, sc_offset;
  logic [1:0] htu_opcode;
  logic [5:0] htu_set_way;
  logic [26:0] htu_addr;
  logic [127:0] sc_data;
  logic isu_rvalid, isu_rready;
  logic [255:0] isu_rdata;
  logic [5:0] isu_rid;
  logic arvalid, arready, rvalid, rready, rlast, awvalid, awready;
  logic wvalid, wready, wlast, bvalid, bready, err_clr;
  logic [31:0] araddr, awaddr;
  logic [5:0] arid, rid, awid, wid, bid;
  logic [3:0] arlen, awlen;
  logic [2:0] arsize, awsize;
  logic [1:0] arburst, awburst, rresp, bresp, err;
  logic [BW-1:0] rdata, wdata;
  logic [BW/8-1:0] wstrb;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [255:0] line; logic [5:0] id; } isu_exp_t;
  typedef struct { logic [127:0] d; logic last; logic [5:0] id; } w_exp_t;
  typedef struct {
    logic [31:0]  byte_addr;
    logic [5:0]   id;
    logic [127:0] a;
    logic [127:0] b;
    logic [255:0] exp_line;
  } rd_vec_t;

  isu_exp_t isu_q[$];
  w_exp_t   w_q[$];
  rd_vec_t  vecs[4];

  bank_biu_ctrl #(.ADDR_WIDTH(32), .BUS_WIDTH(BW), .ID_WIDTH(6), .RD_OTS(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .htu_biu_valid_i(htu_valid), .htu_biu_ready_o(htu_ready),
    .htu_biu_opcode_i(htu_opcode), .htu_biu_set_way_i(htu_set_way), .htu_biu_addr_i(htu_addr),
    .sc_biu_valid_i(sc_valid), .sc_biu_ready_o(sc_ready),
    .sc_biu_data_i(sc_data), .sc_biu_offset_i(sc_offset),
    .biu_isu_rvalid_o(isu_rvalid), .biu_isu_rready_i(isu_rready),
    .biu_isu_rdata_o(isu_rdata), .biu_isu_rid_o(isu_rid),
    .biu_axi3_arvalid_o(arvalid), .biu_axi3_arready_i(arready), .biu_axi3_araddr_o(araddr),
    .biu_axi3_arid_o(arid), .biu_axi3_arlen_o(arlen), .biu_axi3_arsize_o(arsize),
    .biu_axi3_arburst_o(arburst),
    .biu_axi3_rvalid_i(rvalid), .biu_axi3_rready_o(rready), .biu_axi3_rdata_i(rdata),
    .biu_axi3_rid_i(rid), .biu_axi3_rresp_i(rresp), .biu_axi3_rlast_i(rlast),
    .biu_axi3_awvalid_o(awvalid), .biu_axi3_awready_i(awready), .biu_axi3_awaddr_o(awaddr),
    .biu_axi3_awid_o(awid), .biu_axi3_awlen_o(awlen), .biu_axi3_awsize_o(awsize),
    .biu_axi3_awburst_o(awburst),
    .biu_axi3_wvalid_o(wvalid), .biu_axi3_wready_i(wready), .biu_axi3_wdata_o(wdata),
    .biu_axi3_wstrb_o(wstrb), .biu_axi3_wlast_o(wlast), .biu_axi3_wid_o(wid),
    .biu_axi3_bvalid_i(bvalid), .biu_axi3_bready_o(bready), .biu_axi3_bid_i(bid),
    .biu_axi3_bresp_i(bresp),
    .biu_err_o(err), .biu_err_clr_i(err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ISU scoreboard: one expected line per returned refill, in order
  always @(negedge clk) begin
    if (!rst_i && isu_rvalid && isu_rready) begin
      if (isu_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL isu_unexpected: got line %0h with no expected entry", isu_rdata);
      end else begin : b_isu
        isu_exp_t e;
        e = isu_q.pop_front();
        chk("isu_rdata", isu_rdata, e.line);
        chk("isu_rid", isu_rid, e.id);
      end
    end
  end

  // W scoreboard: beats must arrive low half first with wlast on the last
  always @(negedge clk) begin
    if (!rst_i && wvalid && wready) begin
      if (w_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL w_unexpected: got wdata %0h with no expected beat", wdata);
      end else begin : b_w
        w_exp_t e;
        e = w_q.pop_front();
        chk("wdata", wdata, e.d);
        chk("wlast", wlast, e.last);
        chk("wid", wid, e.id);
        chk("wstrb", wstrb, 16'hFFFF);
      end
    end
  end

  task automatic htu_req(input logic [1:0] op, input logic [5:0] sw, input logic [26:0] a,
                         output logic ok);
    htu_valid = 1'b1; htu_opcode = op; htu_set_way = sw; htu_addr = a;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (htu_ready) ok = 1'b1;
      step();
    end
    htu_valid = 1'b0;
  endtask

  task automatic ar_check(input logic [31:0] a, input logic [5:0] id);
    chk("arvalid", arvalid, 1'b1);
    chk("araddr", araddr, a);
    chk("arid", arid, id);
    chk("arlen", arlen, 4'd1);
    chk("arsize", arsize, 3'd4);
    chk("arburst", arburst, 2'b01);
    arready = 1'b1;
    step();
    arready = 1'b0;
  endtask

  task automatic rburst(input logic [127:0] a, input logic [127:0] b, input logic [5:0] id,
                        input logic [1:0] resp0);
    logic got;
    for (int beat = 0; beat < 2; beat++) begin
      rvalid = 1'b1; rdata = (beat == 0) ? a : b; rid = id;
      rlast = (beat == 1); rresp = (beat == 0) ? resp0 : 2'b00;
      got = 1'b0;
      for (int i = 0; i < 64 && !got; i++) begin
        @(negedge clk);
        if (rready) got = 1'b1;
        step();
      end
      chk("r_beat_taken", got, 1'b1);
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
  endtask

  task automatic refill(input logic [31:0] ba, input logic [5:0] id,
                        input logic [127:0] a, input logic [127:0] b, input logic [1:0] resp0);
    logic ok;
    htu_req(2'b00, id, ba[31:5], ok);
    chk("refill_accept", ok, 1'b1);
    ar_check(ba, id);
    isu_q.push_back('{{b, a}, id});
    rburst(a, b, id, resp0);
  endtask

  task automatic send_half(input logic off, input logic [127:0] d);
    logic got;
    sc_valid = 1'b1; sc_offset = off; sc_data = d;
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (sc_ready) got = 1'b1;
      step();
    end
    sc_valid = 1'b0;
    chk("sc_half_taken", got, 1'b1);
  endtask

  task automatic wb_run(input logic [5:0] id, input logic [26:0] la, input logic [127:0] lo,
                        input logic [127:0] hi, input logic [1:0] resp);
    logic ok;
    w_q.push_back('{lo, 1'b0, id});
    w_q.push_back('{hi, 1'b1, id});
    awready = 1'b1; wready = 1'b1;
    htu_req(2'b01, id, la, ok);
    chk("wb_accept", ok, 1'b1);
    chk("wb_awaddr", awaddr, {la, 5'b0});
    send_half(1'b0, lo);
    send_half(1'b1, hi);
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (bready) ok = 1'b1;
      else step();
    end
    chk("wb_bready", ok, 1'b1);
    bvalid = 1'b1; bid = id; bresp = resp;
    step();
    bvalid = 1'b0; bresp = 2'b00; awready = 1'b0;
  endtask

  initial begin : main
    logic ok;
    logic got;
    logic [127:0] wb_lo, wb_hi;

    rst_i = 1'b1;
    htu_valid = 0; htu_opcode = 0; htu_set_way = 0; htu_addr = 0;
    sc_valid = 0; sc_offset = 0; sc_data = 0; isu_rready = 1;
    arready = 0; rvalid = 0; rdata = 0; rid = 0; rresp = 0; rlast = 0;
    awready = 0; wready = 0; bvalid = 0; bid = 0; bresp = 0; err_clr = 0;

    vecs[0] = '{32'h1000_0040, 6'd5, 128'hAAAA_0000_1111_2222_3333_4444_5555_6666,
                128'hBBBB_7777_8888_9999_AAAA_BBBB_CCCC_DDDD, '0};
    vecs[1] = '{32'h0000_0000, 6'd0, 128'h0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, '0};
    vecs[2] = '{32'hFFFF_FFE0, 6'h3F, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF,
                128'hFEDC_BA98_7654_3210_FEDC_BA98_7654_3210, '0};
    vecs[3] = '{32'h8000_1220, 6'd42, 128'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A,
                128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5, '0};
    foreach (vecs[i]) vecs[i].exp_line = {vecs[i].b, vecs[i].a};

    repeat (3) step();
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_wvalid", wvalid, 1'b0);
    chk("rst_bready", bready, 1'b0);
    chk("rst_isu_rvalid", isu_rvalid, 1'b0);
    chk("rst_err", err, 2'b00);
    rst_i = 1'b0;
    step();

    // Table-driven refills with the line returned one cycle after rlast
    foreach (vecs[v]) begin
      refill(vecs[v].byte_addr, vecs[v].id, vecs[v].a, vecs[v].b, 2'b00);
      chk("isu_rvalid_latency", isu_rvalid, 1'b1);
      chk("isu_line_direct", isu_rdata, vecs[v].exp_line);
      repeat (2) step();
    end

    // Reserved opcode: accepted and dropped
    htu_req(2'b10, 6'd7, 27'h1234, ok);
    chk("rsvd_accept", ok, 1'b1);
    step();
    chk("rsvd_no_ar", arvalid, 1'b0);
    chk("rsvd_no_aw", awvalid, 1'b0);

    // Outstanding limit: four AR issued with no data, fifth blocked
    isu_rready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      htu_req(2'b00, 6'(10 + i), 27'(32'h100 + i), ok);
      chk("ots_accept", ok, 1'b1);
      ar_check({27'(32'h100 + i), 5'b0}, 6'(10 + i));
    end
    htu_valid = 1'b1; htu_opcode = 2'b00;
    @(negedge clk);
    chk("ots_fifth_blocked", htu_ready, 1'b0);
    step();
    htu_valid = 1'b0;
    isu_q.push_back('{{128'h10B, 128'h10A}, 6'd10});
    rburst(128'h10A, 128'h10B, 6'd10, 2'b00);
    @(negedge clk);
    chk("ots_full_until_drain", htu_ready, 1'b0);
    step();
    isu_rready = 1'b1;
    step();
    @(negedge clk);
    chk("ots_ready_after_drain", htu_ready, 1'b1);
    step();
    for (int i = 1; i < 4; i++) begin
      isu_q.push_back('{{128'(32'h20B + i), 128'(32'h20A + i)}, 6'(10 + i)});
      rburst(128'(32'h20A + i), 128'(32'h20B + i), 6'(10 + i), 2'b00);
    end
    repeat (3) step();

    // ISU backpressure with a second burst waiting on R
    isu_rready = 1'b0;
    htu_req(2'b00, 6'd20, 27'h300, ok);
    ar_check(32'h0000_6000, 6'd20);
    htu_req(2'b00, 6'd21, 27'h301, ok);
    ar_check(32'h0000_6020, 6'd21);
    isu_q.push_back('{{128'hC1, 128'hC0}, 6'd20});
    rburst(128'hC0, 128'hC1, 6'd20, 2'b00);
    isu_q.push_back('{{128'hD1, 128'hD0}, 6'd21});
    rvalid = 1'b1; rdata = 128'hD0; rid = 6'd21; rlast = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_rready_low", rready, 1'b0);
      step();
    end
    chk("bp_line_held", isu_rdata, {128'hC1, 128'hC0});
    isu_rready = 1'b1;
    rburst(128'hD0, 128'hD1, 6'd21, 2'b00);
    repeat (3) step();
    chk("bp_all_returned", isu_q.size(), 0);

    // Writeback id 9: high half first, duplicate refused, AW late by 3 cycles
    wb_lo = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    wb_hi = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
    w_q.push_back('{wb_lo, 1'b0, 6'd9});
    w_q.push_back('{wb_hi, 1'b1, 6'd9});
    wready = 1'b1; awready = 1'b0;
    htu_req(2'b01, 6'd9, 27'h0123456, ok);
    chk("wb9_accept", ok, 1'b1);
    chk("wb9_awvalid", awvalid, 1'b1);
    chk("wb9_awaddr", awaddr, 32'h0246_8AC0);
    chk("wb9_awid", awid, 6'd9);
    chk("wb9_awlen", awlen, 4'd1);
    chk("wb9_awsize", awsize, 3'd4);
    chk("wb9_awburst", awburst, 2'b01);
    htu_opcode = 2'b01;
    sc_valid = 1'b1; sc_offset = 1'b1; sc_data = wb_hi;
    @(negedge clk);
    chk("wb9_sc_ready_hi", sc_ready, 1'b1);
    chk("wb9_htu_busy", htu_ready, 1'b0);
    step();
    sc_data = 128'hDEAD_BEEF;
    @(negedge clk);
    chk("wb9_sc_dup_blocked", sc_ready, 1'b0);
    chk("wb9_htu_busy", htu_ready, 1'b0);
    step();
    sc_offset = 1'b0; sc_data = wb_lo;
    @(negedge clk);
    chk("wb9_sc_ready_lo", sc_ready, 1'b1);
    step();
    sc_valid = 1'b0;
    chk("wb9_awvalid_held", awvalid, 1'b1);
    chk("wb9_no_wvalid_yet", wvalid, 1'b0);
    awready = 1'b1;
    step();
    awready = 1'b0;
    chk("wb9_aw_done", awvalid, 1'b0);
    chk("wb9_wvalid", wvalid, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bready) got = 1'b1;
      else begin
        chk("wb9_htu_busy_w", htu_ready, 1'b0);
        step();
      end
    end
    chk("wb9_bready", got, 1'b1);
    chk("wb9_htu_busy_b", htu_ready, 1'b0);
    bvalid = 1'b1; bid = 6'd9; bresp = 2'b00;
    step();
    bvalid = 1'b0;
    @(negedge clk);
    chk("wb9_idle_ready", htu_ready, 1'b1);
    chk("wb9_bready_drop", bready, 1'b0);
    chk("wb9_all_beats", w_q.size(), 0);
    chk("wb9_no_err", err, 2'b00);
    step();

    // Error reporting: write SLVERR, clear, then read SLVERR on one beat
    wb_run(6'd3, 27'h0000777, 128'hE0, 128'hE1, 2'b10);
    chk("err_bresp", err, {ERR_EN, 1'b0});
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_cleared", err, 2'b00);
    refill(32'h0000_4000, 6'd33, 128'hF0, 128'hF1, 2'b10);
    chk("err_rresp", err, {1'b0, ERR_EN});
    repeat (2) step();

    // Reset during writeback DATA with a refill AR also pending
    htu_req(2'b00, 6'd30, 27'h0000500, ok);
    chk("rstmid_refill_accept", ok, 1'b1);
    wready = 1'b0; awready = 1'b1;
    htu_req(2'b01, 6'd31, 27'h0000600, ok);
    chk("rstmid_wb_accept", ok, 1'b1);
    send_half(1'b0, 128'h1);
    send_half(1'b1, 128'h2);
    awready = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (wvalid) got = 1'b1;
      else step();
    end
    chk("rstmid_in_data", got, 1'b1);
    chk("rstmid_ar_pending", arvalid, 1'b1);
    step();
    rst_i = 1'b1;
    @(negedge clk);
    htu_opcode = 2'b01;
    #1;
    chk("rstmid_arvalid", arvalid, 1'b0);
    chk("rstmid_awvalid", awvalid, 1'b0);
    chk("rstmid_wvalid", wvalid, 1'b0);
    chk("rstmid_bready", bready, 1'b0);
    chk("rstmid_isu_rvalid", isu_rvalid, 1'b0);
    chk("rstmid_fsm_idle", htu_ready, 1'b1);
    chk("rstmid_rd_cnt", dut.rd_cnt_q, 0);
    chk("rstmid_err", err, 2'b00);
    step();
    rst_i = 1'b0;
    wready = 1'b1;
    step();

    // Recovery after reset
    refill(vecs[2].byte_addr, vecs[2].id, vecs[2].a, vecs[2].b, 2'b00);
    repeat (3) step();
    chk("end_isu_queue_empty", isu_q.size(), 0);
    chk("end_w_queue_empty", w_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bank_biu_ctrl.md
Name: bank_biu_ctrl

Overview:
- Cache-bank bus interface unit: converts HTU refill/writeback requests into AXI3 bursts with a configurable bus width.
- Refill: multi-beat R data is reassembled into a 256-bit line and returned to the ISU tagged with set/way.
- Writeback: the 256-bit line arrives from the SRAM controller in two 128-bit halves, is buffered, then sent as an AW/W burst; the B response closes the transaction.
- Sits between htu/sc/isu and the AXI3 fabric port of one bank.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- BUS_WIDTH, 256, AXI data width; legal values 64, 128, 256.
- ID_WIDTH, 6, AXI ID width; equals the set/way tag width.
- RD_OTS, 4, maximum outstanding refill reads; legal range 1..8.
- Derived: BEATS = 256/BUS_WIDTH; SIZE = log2(BUS_WIDTH/8).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  async active-high reset
- htu_biu_valid_i/ready_o  in/out  1/1  request handshake
- htu_biu_opcode_i  in  2  00 refill, 01 writeback, 1x reserved
- htu_biu_set_way_i  in  ID_WIDTH  line tag
- htu_biu_addr_i  in  ADDR_WIDTH-5  line address
- sc_biu_valid_i/ready_o  in/out  1/1  writeback data handshake
- sc_biu_data_i  in  128  half line
- sc_biu_offset_i  in  1  half select (0 = low half)
- biu_isu_rvalid_o/rready_i  out/in  1/1  refill return handshake
- biu_isu_rdata_o  out  256  line data
- biu_isu_rid_o  out  ID_WIDTH  line tag
- biu_axi3_ar*/r*/aw*/w*/b*: standard AXI3 master channels
  - araddr/awaddr: ADDR_WIDTH
  - ids: ID_WIDTH
  - rdata/wdata: BUS_WIDTH; wstrb: BUS_WIDTH/8
  - len: 4; size: 3; burst: 2; resp: 2
- biu_err_o  out  2  sticky [0] read error, [1] write error
- biu_err_clr_i  in  1  clears biu_err_o

Behaviour:
- Reset: all valid outputs 0; rd_cnt 0; WB FSM IDLE; buffers cleared; biu_err_o 0.
- Reset mid-operation: all in-flight bus transactions are abandoned.
- Constant AR/AW fields: arlen/awlen = BEATS-1; size = SIZE; burst = 01 (INCR); addr = {addr, 5'b0}; arid/awid/wid = set_way; wstrb all ones.
- htu_biu_ready_o:
  - opcode 00: ~ar_hold & (rd_cnt < RD_OTS).
  - opcode 01: wb_state == IDLE.
  - opcode 1x: 1; the request is accepted and discarded.
- Refill AR:
  - An accepted refill loads the AR register; arvalid is asserted the next cycle and held until arready.
  - rd_cnt increments on htu accept and decrements on the isu handshake; both in the same cycle leaves it unchanged.
- Refill R:
  - The slave must not interleave bursts.
  - Beat counter k (0..BEATS-1) writes rdata to line bits [k*BUS_WIDTH +: BUS_WIDTH].
  - On rlast, line and rid are latched and isu_rvalid is set the following cycle.
  - rready = ~isu_rvalid | isu_rready (single line buffer with bypass on drain).
  - rlast arriving at a count other than BEATS-1: the line is still returned and err[0] is set.
- Writeback FSM:
  - IDLE -> ADDR on accept: awvalid asserted.
  - Half-line capture runs concurrently with ADDR: sc_biu_ready_o = 1 while the selected half is not yet filled (states ADDR/DATA).
  - ADDR -> DATA when the AW handshake is done and both halves are filled.
  - DATA: wvalid asserted; beat j carries buffer[j*BUS_WIDTH +: BUS_WIDTH]; wlast on j = BEATS-1.
  - DATA -> RESP after the wlast handshake; bready = 1 in RESP.
  - RESP -> IDLE on bvalid.
  - A duplicate half in the same transaction is not accepted (ready = 0 for that offset).
- Refill and writeback are fully independent and may proceed concurrently.
- Latency:
  - htu accept -> arvalid: 1 cycle.
  - rlast handshake -> isu_rvalid: 1 cycle.

Optional Feature:
- Macro: BIU_ERR_CHECK_EN.
- Defined: non-zero rresp on any beat sets err[0]; non-zero bresp sets err[1]; bits are sticky until biu_err_clr_i; a clear and a set in the same cycle resolves to set.
- Undefined: biu_err_o tied to 0; resp inputs ignored; the rlast-mismatch error is also suppressed.

Test Plan:
- BUS_WIDTH=128, refill addr 0x1000_0040, id 5; slave returns beats A, B with rlast on B -> AR len=1 size=4 addr=0x10000040; isu_rdata={B,A}, rid=5, one cycle after rlast.
- RD_OTS=4: issue 5 back-to-back refills with no R responses -> htu_ready low on the 5th; rises after the first isu handshake.
- Writeback id 9: sc sends the high half before the low half, awready delayed 3 cycles -> W beats in low-to-high order, wlast on the final beat, bready then FSM IDLE; htu_ready for opcode 01 low throughout.
- isu_rready held low for 10 cycles with a second burst pending -> rready low and no data loss; second line returned after the first drains.
- BIU_ERR_CHECK_EN: bresp=2'b10 -> err=2'b10; assert err_clr -> 0; rresp=SLVERR on one beat -> err[0]=1.
- Assert rst_i during writeback DATA state -> all valids 0 next edge; FSM IDLE; rd_cnt 0.
